// File: rtl/ppi_pkg.sv
// Shared constants for the 8255A-style PPI control unit: bus addresses,
// control-word layout, reset control word and Mode 1 Port C bit roles.
package ppi_pkg;

  localparam logic [1:0] ADDR_A    = 2'b00;
  localparam logic [1:0] ADDR_B    = 2'b01;
  localparam logic [1:0] ADDR_C    = 2'b10;
  localparam logic [1:0] ADDR_CTRL = 2'b11;

  localparam int CW_MODE_SET = 7;
  localparam int CW_A_IN     = 4;
  localparam int CW_CU_IN    = 3;
  localparam int CW_B_IN     = 1;
  localparam int CW_CL_IN    = 0;

  localparam logic [1:0] GA_MODE_0 = 2'b00;
  localparam logic [1:0] GA_MODE_1 = 2'b01;

  localparam logic [7:0] CTRL_RESET = 8'h9B;

  localparam int PC_INTR = 3;
  localparam int PC_STB  = 4;
  localparam int PC_INTE = 4;
  localparam int PC_IBF  = 5;

  // Group A mode lives in D6:5; 1x decodes as Mode 0.
  function automatic logic is_mode1(input logic [7:0] cw);
    return cw[6:5] == GA_MODE_1;
  endfunction

endpackage

// File: rtl/ppi_strobe_handshake.sv
// Port A Mode 1 strobed-input handshake: strobe edge detection, input
// latch and the IBF / INTR / INTE flags. Instantiated only under PPI_MODE1_EN.
module ppi_strobe_handshake
  import ppi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode1_i,
  input  logic       clear_i,
  input  logic       stb_pin_i,
  input  logic [7:0] port_a_pin_i,
  input  logic       inte_we_i,
  input  logic       inte_wdata_i,
  input  logic       rd_start_i,
  input  logic       rd_end_i,
  output logic       ibf_o,
  output logic       intr_o,
  output logic       inte_o,
  output logic [7:0] latch_o
);

  logic       stb_s1_q, stb_s2_q;
  logic       ibf_q, ibf_d;
  logic       intr_q, intr_d;
  logic       inte_q, inte_d;
  logic [7:0] latch_q, latch_d;
  logic       stb_fall, stb_rise;

  assign stb_fall = stb_s2_q & ~stb_s1_q;
  assign stb_rise = ~stb_s2_q & stb_s1_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    ibf_d   = ibf_q;
    intr_d  = intr_q;
    inte_d  = inte_q;
    latch_d = latch_q;
    if (clear_i) begin
      ibf_d  = 1'b0;
      intr_d = 1'b0;
      inte_d = 1'b0;
    end else if (mode1_i) begin
      if (inte_we_i) inte_d = inte_wdata_i;
      // Set events are applied after clears so they win on a tie.
      if (rd_end_i) ibf_d = 1'b0;
      if (stb_fall) begin
        ibf_d   = 1'b1;
        latch_d = port_a_pin_i;
      end
      if (rd_start_i) intr_d = 1'b0;
      if (stb_rise && inte_q && ibf_q) intr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_s1_q <= 1'b1;
      stb_s2_q <= 1'b1;
      ibf_q    <= 1'b0;
      intr_q   <= 1'b0;
      inte_q   <= 1'b0;
      latch_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      stb_s1_q <= stb_pin_i;
      stb_s2_q <= stb_s1_q;
      ibf_q    <= ibf_d;
      intr_q   <= intr_d;
      inte_q   <= inte_d;
      latch_q  <= latch_d;
    end
  end

  assign ibf_o   = ibf_q;
  assign intr_o  = intr_q;
  assign inte_o  = inte_q;
  assign latch_o = latch_q;

endmodule

// File: rtl/ppi_control_unit.sv
// PPI 8255A bus interface and control logic: host cycle decode, control word,
// port latches, Port C BSR and direction enables. Mode 1 needs PPI_MODE1_EN.
module ppi_control_unit
  import ppi_pkg::*;
(
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       ChipSelectN,
  input  logic       ReadN,
  input  logic       WriteN,
  input  logic [1:0] Address,
  input  logic [7:0] DataIn,
  output logic [7:0] DataOut,
  output logic       DataOutEnable,
  input  logic [7:0] PortAIn,
  input  logic [7:0] PortBIn,
  input  logic [7:0] PortCIn,
  output logic [7:0] PortAOut,
  output logic [7:0] PortBOut,
  output logic [7:0] PortCOut,
  output logic       PortADir,
  output logic       PortBDir,
  output logic       PortCUpperDir,
  output logic       PortCLowerDir
);

  logic [7:0] ctrl_q, ctrl_d;
  logic [7:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [1:0] wr_addr_q, wr_addr_d;
  logic       wr_pend_q, wr_pend_d;
  logic [7:0] dout_q, dout_d;
  logic [1:0] rd_addr_q, rd_addr_d;
  logic       rd_act_q, rd_act_d;
  logic       rd_n_prev_q;

  logic       commit, mode_set, bsr, bsr_val, bsr_reserved;
  logic [2:0] bsr_bit;
  logic       rd_start, rd_end;
  logic [7:0] rd_data, c_view;
  logic       mode1, ibf, intr, inte;
  logic [7:0] a_strobed;

  // A write commits on the first cycle WriteN is back high.
  assign commit   = WriteN & wr_pend_q;
  assign mode_set = commit && (wr_addr_q == ADDR_CTRL) && wr_data_q[CW_MODE_SET];
  assign bsr      = commit && (wr_addr_q == ADDR_CTRL) && !wr_data_q[CW_MODE_SET];
  assign bsr_bit  = wr_data_q[3:1];
  assign bsr_val  = wr_data_q[0];
  assign bsr_reserved = mode1 && (bsr_bit == 3'(PC_INTR) || bsr_bit == 3'(PC_INTE) ||
                                  bsr_bit == 3'(PC_IBF));

  // A read attempted while WriteN is low loses to the write.
  assign rd_start = ~ReadN & ~ChipSelectN & rd_n_prev_q & WriteN;
  assign rd_end   = rd_act_q & ReadN;

  assign PortADir      = ~ctrl_q[CW_A_IN];
  assign PortBDir      = ~ctrl_q[CW_B_IN];
  assign PortCUpperDir = ~ctrl_q[CW_CU_IN];
  assign PortCLowerDir = ~ctrl_q[CW_CL_IN];

`ifdef PPI_MODE1_EN
  assign mode1 = is_mode1(ctrl_q);

  ppi_strobe_handshake u_handshake (
    .clk          (Clock),
    .rst_n        (ResetN),
    .mode1_i      (mode1),
    .clear_i      (mode_set),
    .stb_pin_i    (PortCIn[PC_STB]),
    .port_a_pin_i (PortAIn),
    .inte_we_i    (bsr && (bsr_bit == 3'(PC_INTE))),
    .inte_wdata_i (bsr_val),
    .rd_start_i   (rd_start && (Address == ADDR_A)),
    .rd_end_i     (rd_end && (rd_addr_q == ADDR_A)),
    .ibf_o        (ibf),
    .intr_o       (intr),
    .inte_o       (inte),
    .latch_o      (a_strobed)
  );
`else
  assign mode1     = 1'b0;
  assign ibf       = 1'b0;
  assign intr      = 1'b0;
  assign inte      = 1'b0;
  assign a_strobed = '0;
`endif

  always_comb begin
    wr_pend_d = wr_pend_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (!WriteN && !ChipSelectN) begin
      wr_pend_d = 1'b1;
      wr_addr_d = Address;
      wr_data_d = DataIn;
    end else if (WriteN) begin
      wr_pend_d = 1'b0;
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    if (commit) begin
      case (wr_addr_q)
        ADDR_A: a_d = wr_data_q;
        ADDR_B: b_d = wr_data_q;
        ADDR_C: c_d = wr_data_q;
        default: begin
          if (mode_set) begin
            ctrl_d = wr_data_q;
            a_d    = '0;
            b_d    = '0;
            c_d    = '0;
          end else if (!bsr_reserved) begin
            c_d[bsr_bit] = bsr_val;
          end
        end
      endcase
    end
  end

  // Each Port C nibble follows its own direction; Mode 1 overlays status bits.
  always_comb begin
    c_view[7:4] = PortCUpperDir ? c_q[7:4] : PortCIn[7:4];
    c_view[3:0] = PortCLowerDir ? c_q[3:0] : PortCIn[3:0];
    if (mode1) begin
      c_view[PC_IBF]  = ibf;
      c_view[PC_INTE] = inte;
      c_view[PC_INTR] = intr;
    end
    case (Address)
      ADDR_A:  rd_data = mode1 ? a_strobed : (PortADir ? a_q : PortAIn);
      ADDR_B:  rd_data = PortBDir ? b_q : PortBIn;
      ADDR_C:  rd_data = c_view;
      default: rd_data = ctrl_q;
    endcase
  end

  always_comb begin
    dout_d    = dout_q;
    rd_addr_d = rd_addr_q;
    rd_act_d  = rd_act_q;
    if (rd_start) begin
      dout_d    = rd_data;
      rd_addr_d = Address;
      rd_act_d  = 1'b1;
    end else if (rd_end) begin
      rd_act_d  = 1'b0;
    end
  end

  // Read-edge history resets low so a read held across reset stays aborted.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      ctrl_q      <= CTRL_RESET;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      dout_q      <= '0;
      rd_addr_q   <= '0;
      rd_act_q    <= 1'b0;
      rd_n_prev_q <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      wr_pend_q   <= wr_pend_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      dout_q      <= dout_d;
      rd_addr_q   <= rd_addr_d;
      rd_act_q    <= rd_act_d;
      rd_n_prev_q <= ReadN;
    end
  end

  assign PortAOut      = a_q;
  assign PortBOut      = b_q;
  assign PortCOut      = c_q;
  assign DataOut       = dout_q;
  assign DataOutEnable = rd_act_q;

endmodule

// File: tb/tb_ppi_control_unit.sv
// Self-checking bench for ppi_control_unit: directed scenarios plus random
// bus traffic compared against a behavioural PPI model.
module tb_ppi_control_unit;

  logic       Clock = 1'b0;
  logic       ResetN, ChipSelectN, ReadN, WriteN;
  logic [1:0] Address;
  logic [7:0] DataIn, DataOut;
  logic       DataOutEnable;
  logic [7:0] PortAIn, PortBIn, PortCIn;
  logic [7:0] PortAOut, PortBOut, PortCOut;
  logic       PortADir, PortBDir, PortCUpperDir, PortCLowerDir;

  ppi_control_unit dut (
    .Clock(Clock), .ResetN(ResetN), .ChipSelectN(ChipSelectN), .ReadN(ReadN),
    .WriteN(WriteN), .Address(Address), .DataIn(DataIn), .DataOut(DataOut),
    .DataOutEnable(DataOutEnable), .PortAIn(PortAIn), .PortBIn(PortBIn),
    .PortCIn(PortCIn), .PortAOut(PortAOut), .PortBOut(PortBOut),
    .PortCOut(PortCOut), .PortADir(PortADir), .PortBDir(PortBDir),
    .PortCUpperDir(PortCUpperDir), .PortCLowerDir(PortCLowerDir)
  );

  always #5 Clock = ~Clock;

`ifdef PPI_MODE1_EN
  localparam bit M1_BUILD = 1'b1;
`else
  localparam bit M1_BUILD = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the programmer-visible state.
  logic [7:0] m_ctrl, m_a, m_b, m_c, m_sa;
  bit         m_ibf, m_intr, m_inte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_mode1();
    return M1_BUILD && (m_ctrl[6:5] == 2'b01);
  endfunction

  task automatic m_reset();
    m_ctrl = 8'h9B;
    m_a = 0; m_b = 0; m_c = 0; m_sa = 0;
    m_ibf = 0; m_intr = 0; m_inte = 0;
  endtask

  task automatic m_write(input logic [1:0] addr, input logic [7:0] d);
    int bitn;
    case (addr)
      2'd0: m_a = d;
      2'd1: m_b = d;
      2'd2: m_c = d;
      default: begin
        if (d[7]) begin
          m_ctrl = d;
          m_a = 0; m_b = 0; m_c = 0;
          m_ibf = 0; m_intr = 0; m_inte = 0;
        end else begin
          bitn = int'(d[3:1]);
          if (m_mode1() && bitn == 4) m_inte = d[0];
          else if (!(m_mode1() && (bitn == 3 || bitn == 5))) m_c[bitn] = d[0];
        end
      end
    endcase
  endtask

  function automatic logic [7:0] m_read_val(input logic [1:0] addr);
    logic [7:0] v;
    case (addr)
      2'd0: v = m_mode1() ? m_sa : (m_ctrl[4] ? PortAIn : m_a);
      2'd1: v = m_ctrl[1] ? PortBIn : m_b;
      2'd2: begin
        v[7:4] = m_ctrl[3] ? PortCIn[7:4] : m_c[7:4];
        v[3:0] = m_ctrl[0] ? PortCIn[3:0] : m_c[3:0];
        if (m_mode1()) begin
          v[5] = m_ibf; v[4] = m_inte; v[3] = m_intr;
        end
      end
      default: v = m_ctrl;
    endcase
    return v;
  endfunction

  task automatic check_outs(input string tag);
    check({tag, ".aout"}, PortAOut, m_a);
    check({tag, ".bout"}, PortBOut, m_b);
    check({tag, ".cout"}, PortCOut, m_c);
    check({tag, ".dirs"}, {PortADir, PortBDir, PortCUpperDir, PortCLowerDir},
          {~m_ctrl[4], ~m_ctrl[1], ~m_ctrl[3], ~m_ctrl[0]});
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [7:0] d);
    @(negedge Clock);
    ChipSelectN = 0; WriteN = 0; Address = addr; DataIn = d;
    @(negedge Clock);
    WriteN = 1; ChipSelectN = 1;
    Address = 2'($urandom); DataIn = 8'($urandom);
    @(posedge Clock);
    m_write(addr, d);
    @(negedge Clock);
  endtask

  task automatic bus_read(input string tag, input logic [1:0] addr, input int hold);
    logic [7:0] exp;
    @(negedge Clock);
    ChipSelectN = 0; ReadN = 0; Address = addr;
    exp = m_read_val(addr);
    @(negedge Clock);
    check({tag, ".data"}, DataOut, exp);
    check({tag, ".oe"}, DataOutEnable, 1'b1);
    repeat (hold) begin
      @(negedge Clock);
      check({tag, ".hold"}, {DataOutEnable, DataOut}, {1'b1, exp});
    end
    ReadN = 1; ChipSelectN = 1;
    if (m_mode1() && addr == 2'd0) begin
      m_intr = 0;
      m_ibf  = 0;
    end
    @(negedge Clock);
    check({tag, ".oe_off"}, DataOutEnable, 1'b0);
  endtask

  // Strobe low for low_cycles, then high; model applies fall then rise rules.
  task automatic strobe(input logic [7:0] v, input int low_cycles);
    PortAIn = v;
    @(negedge Clock);
    PortCIn[4] = 1'b0;
    repeat (low_cycles) @(negedge Clock);
    PortCIn[4] = 1'b1;
    repeat (3) @(negedge Clock);
    m_sa = v; m_ibf = 1;
    if (m_inte && m_ibf) m_intr = 1;
  endtask

  initial begin
    logic [7:0] r;
    int op;
    ChipSelectN = 1; ReadN = 1; WriteN = 1; Address = 0; DataIn = 0;
    PortAIn = 0; PortBIn = 0; PortCIn = 8'h10;
    ResetN = 0;
    m_reset();
    repeat (3) @(negedge Clock);
    check_outs("reset");
    check("reset.dout", {DataOutEnable, DataOut}, 9'h000);
    ResetN = 1;

    bus_read("rd_ctrl_reset", 2'd3, 0);

    bus_write(2'd3, 8'h80);
    check_outs("mode0_out");
    bus_write(2'd0, 8'h5A);
    check("wr_a.aout", PortAOut, 8'h5A);
    check("wr_a.dir", PortADir, 1'b1);
    bus_read("rd_a", 2'd0, 1);

    bus_write(2'd2, 8'h00);
    bus_write(2'd3, 8'h0F);
    bus_write(2'd3, 8'h08);
    check("bsr.cout", PortCOut, 8'h80);
    check_outs("bsr");

    bus_write(2'd3, 8'h82);
    PortBIn = 8'hC3;
    check_outs("b_in");
    bus_read("rd_b_in", 2'd1, 3);

    // Simultaneous read and write: write wins, read never starts.
    bus_write(2'd3, 8'h80);
    @(negedge Clock);
    ChipSelectN = 0; ReadN = 0; WriteN = 0; Address = 2'd1; DataIn = 8'h77;
    @(negedge Clock);
    check("rdwr.oe_busy", DataOutEnable, 1'b0);
    ReadN = 1; WriteN = 1; ChipSelectN = 1;
    @(posedge Clock);
    m_write(2'd1, 8'h77);
    @(negedge Clock);
    check("rdwr.oe_after", DataOutEnable, 1'b0);
    check_outs("rdwr");

    bus_write(2'd3, 8'hB0);
    bus_write(2'd3, 8'h09);
    check_outs("m1_setup");
    bus_read("m1_rd_c0", 2'd2, 0);
    if (M1_BUILD) begin
      strobe(8'h3C, 2);
      bus_read("m1_rd_c_flags", 2'd2, 0);
      bus_read("m1_rd_a", 2'd0, 2);
      bus_read("m1_rd_c_clr", 2'd2, 0);
      bus_write(2'd3, 8'h08);
      strobe(8'hA5, 1);
      bus_read("m1_noint", 2'd2, 0);
      strobe(8'h5A, 3);
      bus_read("m1_ovr_c", 2'd2, 0);
      bus_read("m1_ovr_a", 2'd0, 0);
      bus_write(2'd3, 8'h0B);
      check_outs("m1_bsr5");
    end

    for (int i = 0; i < 80; i++) begin
      r = 8'($urandom);
      PortAIn = 8'($urandom);
      PortBIn = 8'($urandom);
      PortCIn = 8'($urandom) | 8'h10;
      op = int'($urandom_range(0, 3));
      case (op)
        0: bus_write(2'd3, r | 8'h80);
        1: bus_write(2'd3, r & 8'h0F);
        2: bus_write(2'($urandom_range(0, 2)), r);
        default: bus_read($sformatf("rnd_rd%0d", i), 2'($urandom_range(0, 3)), 0);
      endcase
      check_outs($sformatf("rnd%0d", i));
    end

    // Reset pulse in the middle of a read.
    bus_write(2'd3, 8'h80);
    bus_write(2'd1, 8'h44);
    @(negedge Clock);
    ChipSelectN = 0; ReadN = 0; Address = 2'd3;
    @(negedge Clock);
    check("rst_rd.oe_pre", DataOutEnable, 1'b1);
    #2 ResetN = 0;
    #1;
    m_reset();
    check("rst_rd.oe", DataOutEnable, 1'b0);
    check("rst_rd.dout", DataOut, 8'h00);
    check_outs("rst_rd");
    @(negedge Clock);
    ResetN = 1; ReadN = 1; ChipSelectN = 1;
    bus_read("rst_rd_ctrl", 2'd3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ppi_control_unit.md
# ppi_control_unit

Bus-interface and control-logic block of the PPI 8255A. Sits between the host bus and the three 8-bit port datapaths (A, B, C). Decodes host read/write cycles, holds the control word, and drives the per-port direction enables that gate the bidirectional port drivers. Owns the port output latches, Port C bit set/reset, and the optional Mode 1 strobed-input handshake on Port A.

## Interface
- No parameters; widths fixed at 8 bits.
- `Clock` in 1: single system clock; all state changes on rising edge.
- `ResetN` in 1: asynchronous, active-low reset.
- `ChipSelectN` in 1: active-low chip select, synchronous to `Clock`.
- `ReadN` in 1: active-low read strobe, synchronous to `Clock`.
- `WriteN` in 1: active-low write strobe, synchronous to `Clock`.
- `Address` in 2: 00=A, 01=B, 10=C, 11=control.
- `DataIn` in 8: host write data.
- `DataOut` out 8: host read data, registered.
- `DataOutEnable` out 1: high while a read is in progress; gates the host bus driver.
- `PortAIn`, `PortBIn`, `PortCIn` in 8 each: pin values.
- `PortAOut`, `PortBOut`, `PortCOut` out 8 each: output latches.
- `PortADir`, `PortBDir` out 1 each: 1=output-drive enable.
- `PortCUpperDir`, `PortCLowerDir` out 1 each: 1=output for PC7:4 / PC3:0.

## Operation
- Write commit: on the first cycle `WriteN` is sampled high after being sampled low with `ChipSelectN` low. Address and data come from the last low-`WriteN` cycle.
- Control write with D7=1 (mode set):
  - D6:5: Group A mode. 00 = Mode 0; 01 = Mode 1; 1x is treated as Mode 0.
  - D4: A input. D3: PC upper input. D1: B input. D0: PC lower input. D2 is ignored; Group B is always Mode 0.
  - A mode set clears all three output latches, IBF, INTR and INTE.
- Control write with D7=0 (BSR): sets `PortCOut[D3:1]` = D0. Other bits unchanged.
  - In Mode 1, BSR of bit 4 writes INTE instead of the latch.
  - In Mode 1, BSR of bits 3 and 5 has no effect.
- Port writes:
  - The latch always updates, in any direction.
  - Pins are driven only when the corresponding Dir is 1.
- Reads:
  - Output port: returns the latch.
  - Input port: returns the pins sampled at read start.
  - Address 11: returns the current control word.
  - Port C mixed direction: each nibble follows its own Dir.
- Mode 1 (Port A strobed input): PC4 = strobe `PortCIn[4]`, active-low; PC5 = IBF; PC3 = INTR.
  - Strobe falling edge (sampled): latch `PortAIn`, set IBF.
  - Strobe rising edge: set INTR if INTE=1 and IBF=1.
  - Read of A: INTR clears at read start; IBF clears at read end.
  - A strobe while IBF=1 overwrites the latch; IBF stays 1.
  - Set events win over simultaneous clears.
  - A Port C read returns IBF at bit 5, INTE at bit 4, INTR at bit 3.
- `ResetN` low: control word = 0x9B (all inputs, Mode 0). All `*Out` = 0, all Dir = 0, `DataOut` = 0, `DataOutEnable` = 0, IBF/INTR/INTE = 0. A write or read in flight is aborted.

## Timing
- Read start = edge k where `ReadN` and `ChipSelectN` are both sampled low, after `ReadN` was high.
  - `DataOut` and `DataOutEnable` are valid after edge k.
  - `DataOut` holds until `ReadN` is sampled high; `DataOutEnable` drops on that edge.
- Write effect (latch, Dir, BSR, INTE) is visible the cycle after the commit edge.
- A Mode 1 strobe edge is detected one cycle after the pin changes (one register stage). IBF/INTR are visible the cycle after detection.
- Simultaneous read and write with `ChipSelectN` low: the write commits; the read is ignored.

## Configuration
- `PPI_MODE1_EN` defined: the Mode 1 handshake is compiled in as described above.
- `PPI_MODE1_EN` undefined:
  - D6:5 = 01 is treated as Mode 0.
  - IBF/INTR/INTE are absent.
  - PC3–PC5 behave as plain Mode 0 bits.

## Structure
- Package `ppi_pkg` holds:
  - address constants;
  - control-word bit positions and mode encodings;
  - reset control word 0x9B;
  - Mode 1 Port C bit indices.
- Sub-module `ppi_strobe_handshake` (compiled under `PPI_MODE1_EN`): strobe edge detection, input latch, IBF/INTR/INTE.

## Test plan
- Reset, then read control → 0x9B. All Dir = 0. All `*Out` = 0.
- Write control 0x80, then write A 0x5A → `PortADir`=1, `PortAOut`=0x5A one cycle after commit. Read A → 0x5A.
- Mode 0 all outputs; write C 0x00. BSR 0x0F, then 0x08 → PC7=1, PC4=0, `PortCOut`=0x80.
- Write control 0x82 (B input); drive `PortBIn`=0xC3. Read B → `DataOut`=0xC3 with `DataOutEnable`=1 until `ReadN` high.
- Mode 1 (control 0xB0), BSR 0x09 (INTE=1), `PortAIn`=0x3C. Strobe low 2 cycles, then high → IBF=1, then INTR=1. Read A → 0x3C, INTR clears at start, IBF clears at end.
- Mid-read `ResetN` pulse low → `DataOutEnable`=0 immediately, control 0x9B.
